// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD display scheduler.
// Digit codes and converter result layout used by the top and the bench.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CAPT
    } state_t;

    typedef struct packed {
        logic [3:0] cen;
        logic [3:0] dec;
        logic [3:0] uni;
    } bcd3_t;

    localparam logic [3:0] TAG_A = 4'hA;
    localparam logic [3:0] TAG_B = 4'hB;
    localparam logic [3:0] BLANK = 4'hF;

endpackage

// File: rtl/module_bcd_display_sched_if.sv
// Requester handshakes, display select, capture status and 7-seg drive of the scheduler.
// master = requester/display side, slave = scheduler.
interface module_bcd_display_sched_if;

    logic       req_a_valid;
    logic [7:0] req_a_data;
    logic       req_a_ready;
    logic       req_b_valid;
    logic [7:0] req_b_data;
    logic       req_b_ready;
    logic       show_b;
    logic       res_done;
    logic       res_src;
    logic [3:0] digito;
    logic [3:0] anodos;

    modport master (
        output req_a_valid, req_a_data, req_b_valid, req_b_data, show_b,
        input  req_a_ready, req_b_ready, res_done, res_src, digito, anodos
    );

    modport slave (
        input  req_a_valid, req_a_data, req_b_valid, req_b_data, show_b,
        output req_a_ready, req_b_ready, res_done, res_src, digito, anodos
    );

endinterface

// File: rtl/module_binary_to_bcd.sv
// Combinational 8-bit binary to 3-digit BCD converter (shift-and-add-3).
// Hundreds range 0..2, tens and units 0..9.
module module_binary_to_bcd (
    input  logic [7:0] bin,
    output logic [3:0] centenas,
    output logic [3:0] decenas,
    output logic [3:0] unidades
);

    logic [19:0] sr;

    always_comb begin
        sr = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sr[11:8] > 4'd4)  sr[11:8]  = sr[11:8]  + 4'd3;
            if (sr[15:12] > 4'd4) sr[15:12] = sr[15:12] + 4'd3;
            if (sr[19:16] > 4'd4) sr[19:16] = sr[19:16] + 4'd3;
            sr = {sr[18:0], 1'b0};
        end
        centenas = sr[19:16];
        decenas  = sr[15:12];
        unidades = sr[11:8];
    end

endmodule

// File: rtl/module_bcd_display_sched.sv
// Round-robin sharing of one binary-to-BCD converter between two requesters,
// with per-requester result storage and a multiplexed 4-digit 7-seg scan.
module module_bcd_display_sched
    import bcd_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 10000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input logic                          clk,
    input logic                          rst_n,
    module_bcd_display_sched_if.slave    bus
);

    localparam int unsigned     CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] DivMax = CntW'(REFRESH_DIV - 1);

    state_t      state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;   // 0 = A has priority, 1 = B
    logic        src_q, src_d;
    logic [7:0]  bin_q, bin_d;
    logic        res_src_q;
    bcd3_t       res_a_q, res_b_q;
    bcd3_t       conv;
    logic        grant_a, grant_b;

    logic [CntW-1:0] div_cnt_q;
    logic [1:0]      dig_idx_q, dig_next;
    logic [3:0]      digito_q, digito_d;
    logic [3:0]      anodos_q, anodos_d;
    logic            wrap;

    module_binary_to_bcd u_bin2bcd (
        .bin      (bin_q),
        .centenas (conv.cen),
        .decenas  (conv.dec),
        .unidades (conv.uni)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        src_d    = src_q;
        bin_d    = bin_q;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        unique case (state_q)
            IDLE: begin
                grant_a = bus.req_a_valid && (!bus.req_b_valid || !rr_ptr_q);
                grant_b = bus.req_b_valid && (!bus.req_a_valid ||  rr_ptr_q);
                if (grant_a || grant_b) begin
                    state_d  = LOAD;
                    src_d    = grant_b;
                    bin_d    = grant_b ? bus.req_b_data : bus.req_a_data;
                    rr_ptr_d = ~grant_b;
                end
            end
            LOAD:    state_d = CAPT;
            CAPT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            src_q     <= 1'b0;
            bin_q     <= 8'd0;
            res_src_q <= 1'b0;
            res_a_q   <= '0;
            res_b_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            src_q    <= src_d;
            bin_q    <= bin_d;
            if (state_q == CAPT) begin
                res_src_q <= src_q;
                if (src_q) res_b_q <= conv;
                else       res_a_q <= conv;
            end
        end
    end

    assign bus.req_a_ready = grant_a & rst_n;
    assign bus.req_b_ready = grant_b & rst_n;
    assign bus.res_done    = (state_q == CAPT);
    assign bus.res_src     = (state_q == CAPT) ? src_q : res_src_q;

    // Outputs are only reloaded at a slot boundary, so a capture never glitches a slot.
    always_comb begin
        bcd3_t      slot;
        logic [3:0] val;
        logic       blank;
        dig_next = dig_idx_q + 2'd1;
        slot     = bus.show_b ? res_b_q : res_a_q;
        val      = BLANK;
        blank    = 1'b0;
        unique case (dig_next)
            2'd0: val = slot.uni;
            2'd1: begin
                val   = slot.dec;
                blank = BLANK_LZ && (slot.cen == 4'd0) && (slot.dec == 4'd0);
            end
            2'd2: begin
                val   = slot.cen;
                blank = BLANK_LZ && (slot.cen == 4'd0);
            end
            2'd3: val = bus.show_b ? TAG_B : TAG_A;
        endcase
        digito_d = blank ? BLANK : val;
        anodos_d = blank ? 4'b1111 : ~(4'b0001 << dig_next);
    end

    assign wrap = (div_cnt_q == DivMax);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            dig_idx_q <= 2'd0;
            digito_q  <= BLANK;
            anodos_q  <= 4'b1111;
        end else if (wrap) begin
            div_cnt_q <= '0;
            dig_idx_q <= dig_next;
            digito_q  <= digito_d;
            anodos_q  <= anodos_d;
        end else begin
            div_cnt_q <= div_cnt_q + CntW'(1);
        end
    end

    assign bus.digito = digito_q;
    assign bus.anodos = anodos_q;

endmodule

// File: tb/tb_module_bcd_display_sched.sv
// Directed, table-driven bench for the BCD display scheduler (REFRESH_DIV=4, BLANK_LZ=1).
// Display digits and anodes are written as hex nibbles {idx3,idx2,idx1,idx0}.
module tb_module_bcd_display_sched;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    module_bcd_display_sched_if bus ();

    module_bcd_display_sched #(
        .REFRESH_DIV (4),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        src;
        logic [7:0]  val;
        logic        show;
        logic [15:0] dig;
        logic [15:0] an;
        string       name;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transfer one value from a single requester; optionally check the capture pulse.
    task automatic do_xfer(input logic src, input logic [7:0] val, input bit check_done,
                           input string name);
        logic got;
        got = 1'b0;
        if (src) begin bus.req_b_valid = 1'b1; bus.req_b_data = val; end
        else     begin bus.req_a_valid = 1'b1; bus.req_a_data = val; end
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if ((src ? bus.req_b_ready : bus.req_a_ready) === 1'b1) got = 1'b1;
            else step();
        end
        check({name, " grant"}, {7'd0, got}, 8'd1);
        step();
        bus.req_a_valid = 1'b0;
        bus.req_b_valid = 1'b0;
        bus.req_a_data  = ~val;
        bus.req_b_data  = ~val;
        if (check_done) begin
            @(negedge clk);
            check({name, " done t+1"}, {7'd0, bus.res_done}, 8'd0);
            step();
            @(negedge clk);
            check({name, " done t+2"}, {7'd0, bus.res_done}, 8'd1);
            check({name, " src t+2"}, {7'd0, bus.res_src}, {7'd0, src});
            step();
        end
    endtask

    // Leaves the caller at the negedge of the first cycle of a units-digit slot.
    task automatic align_slot0(input string name);
        logic [3:0] prev;
        logic       found;
        prev  = 4'b1110;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            @(negedge clk);
            if (bus.anodos === 4'b1110 && prev !== 4'b1110) found = 1'b1;
            prev = bus.anodos;
        end
        check({name, " slot0 found"}, {7'd0, found}, 8'd1);
    endtask

    task automatic check_scan(input logic show, input logic [15:0] dig, input logic [15:0] an,
                              input string name);
        bus.show_b = show;
        repeat (17) step();
        align_slot0(name);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s digito%0d", name, k), {4'd0, bus.digito}, {4'd0, dig[k*4 +: 4]});
            check($sformatf("%s anodos%0d", name, k), {4'd0, bus.anodos}, {4'd0, an[k*4 +: 4]});
            if (k < 3) repeat (4) @(negedge clk);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0] = '{1'b0, 8'd255, 1'b0, 16'hA255, 16'h7BDE, "A255"};
        vecs[1] = '{1'b1, 8'd120, 1'b1, 16'hB120, 16'h7BDE, "B120"};
        vecs[2] = '{1'b0, 8'd7,   1'b0, 16'hAFF7, 16'h7FFE, "A7"};
        vecs[3] = '{1'b0, 8'd0,   1'b0, 16'hAFF0, 16'h7FFE, "A0"};
        vecs[4] = '{1'b1, 8'd50,  1'b1, 16'hBF50, 16'h7FDE, "B50"};
        vecs[5] = '{1'b0, 8'd105, 1'b0, 16'hA105, 16'h7BDE, "A105"};
        vecs[6] = '{1'b1, 8'd9,   1'b0, 16'hA105, 16'h7BDE, "B9 showA"};
        vecs[7] = '{1'b1, 8'd200, 1'b1, 16'hB200, 16'h7BDE, "B200"};

        rst_n           = 1'b0;
        bus.req_a_valid = 1'b1;
        bus.req_a_data  = 8'd1;
        bus.req_b_valid = 1'b1;
        bus.req_b_data  = 8'd2;
        bus.show_b      = 1'b0;

        // Reset held for 3 cycles with both requesters asking.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst anodos", {4'd0, bus.anodos}, 8'h0F);
        check("rst digito", {4'd0, bus.digito}, 8'h0F);
        check("rst ready_a", {7'd0, bus.req_a_ready}, 8'd0);
        check("rst ready_b", {7'd0, bus.req_b_ready}, 8'd0);
        check("rst res_done", {7'd0, bus.res_done}, 8'd0);
        check("rst res_src", {7'd0, bus.res_src}, 8'd0);
        bus.req_a_valid = 1'b0;
        bus.req_b_valid = 1'b0;
        step();
        rst_n = 1'b1;

        // Both held valid: grants A at 0, B at 3, A at 6.
        bus.req_a_valid = 1'b1;
        bus.req_a_data  = 8'd7;
        bus.req_b_valid = 1'b1;
        bus.req_b_data  = 8'd120;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("rr ready_a c%0d", i), {7'd0, bus.req_a_ready},
                  {7'd0, (i == 0 || i == 6) ? 1'b1 : 1'b0});
            check($sformatf("rr ready_b c%0d", i), {7'd0, bus.req_b_ready},
                  {7'd0, (i == 3) ? 1'b1 : 1'b0});
            check($sformatf("rr res_done c%0d", i), {7'd0, bus.res_done},
                  {7'd0, (i == 2 || i == 5 || i == 8) ? 1'b1 : 1'b0});
            if (i == 2 || i == 5 || i == 8)
                check($sformatf("rr res_src c%0d", i), {7'd0, bus.res_src},
                      {7'd0, (i == 5) ? 1'b1 : 1'b0});
            step();
        end
        bus.req_a_valid = 1'b0;
        bus.req_b_valid = 1'b0;
        check_scan(1'b1, 16'hB120, 16'h7BDE, "rr showB");
        check_scan(1'b0, 16'hAFF7, 16'h7FFE, "rr showA");

        // SHOW_B toggled mid-slot only affects the next slot; 4-cycle slots wrap 0111->1110.
        bus.show_b = 1'b0;
        repeat (17) step();
        align_slot0("toggle");
        check("toggle c0 digito", {4'd0, bus.digito}, 8'h07);
        step();
        bus.show_b = 1'b1;
        repeat (3) @(negedge clk);
        check("toggle c3 digito", {4'd0, bus.digito}, 8'h07);
        check("toggle c3 anodos", {4'd0, bus.anodos}, 8'h0E);
        @(negedge clk);
        check("toggle c4 digito", {4'd0, bus.digito}, 8'h02);
        check("toggle c4 anodos", {4'd0, bus.anodos}, 8'h0D);
        repeat (4) @(negedge clk);
        check("toggle c8 digito", {4'd0, bus.digito}, 8'h01);
        check("toggle c8 anodos", {4'd0, bus.anodos}, 8'h0B);
        repeat (4) @(negedge clk);
        check("toggle c12 digito", {4'd0, bus.digito}, 8'h0B);
        check("toggle c12 anodos", {4'd0, bus.anodos}, 8'h07);
        repeat (4) @(negedge clk);
        check("toggle c16 digito", {4'd0, bus.digito}, 8'h00);
        check("toggle c16 anodos", {4'd0, bus.anodos}, 8'h0E);
        step();
        bus.show_b = 1'b0;

        foreach (vecs[i]) begin
            do_xfer(vecs[i].src, vecs[i].val, 1'b1, vecs[i].name);
            check_scan(vecs[i].show, vecs[i].dig, vecs[i].an, vecs[i].name);
        end

        // Reset during LOAD: no capture, results cleared, priority back to A.
        do_xfer(1'b0, 8'd99, 1'b0, "rstload");
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rstload res_done c%0d", i), {7'd0, bus.res_done}, 8'd0);
            step();
        end
        rst_n           = 1'b1;
        bus.req_a_valid = 1'b1;
        bus.req_a_data  = 8'd1;
        bus.req_b_valid = 1'b1;
        bus.req_b_data  = 8'd2;
        @(negedge clk);
        check("rstload rr ready_a", {7'd0, bus.req_a_ready}, 8'd1);
        check("rstload rr ready_b", {7'd0, bus.req_b_ready}, 8'd0);
        bus.req_a_valid = 1'b0;
        bus.req_b_valid = 1'b0;
        step();
        check_scan(1'b0, 16'hAFF0, 16'h7FFE, "rstload A cleared");
        check_scan(1'b1, 16'hBFF0, 16'h7FFE, "rstload B cleared");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
